hs_rx_fifo: RTL and testbench



---
 rtl/hs_pkg.sv | 17 +
 rtl/hs_fifo_ram.sv | 26 ++
 rtl/hs_rx_fifo.sv | 77 +++++++
 tb/tb_hs_rx_fifo.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hs_pkg.sv
// Shared constants and helpers for the handshake receive path: default beat
// width, pointer-width helper and statistics counter width/saturation value.
package hs_pkg;

   localparam int DATA_W_DEF = 32;
   localparam int STATS_W    = 16;
   localparam logic [STATS_W-1:0] STATS_MAX = 16'hFFFF;

   // Smallest r such that 2**r >= n.
   function automatic int clog2(input int n);
      int r;
      r = 0;
      while ((1 << r) < n) r++;
      return r;
   endfunction

endpackage

// File: rtl/hs_fifo_ram.sv
// Storage array for hs_rx_fifo: one clocked write port and an asynchronous
// read port so the head entry falls through without a read cycle.
module hs_fifo_ram
   import hs_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF,
   parameter int DEPTH  = 4,
   parameter int AW     = clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              we,
   input  logic [AW-1:0]     waddr,
   input  logic [DATA_W-1:0] wdata,
   input  logic [AW-1:0]     raddr,
   output logic [DATA_W-1:0] rdata
);

   logic [DATA_W-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
   end

   assign rdata = mem[raddr];

endmodule

// File: rtl/hs_rx_fifo.sv
// First-word-fall-through elastic buffer between the handshake slave and its
// consumer. Define HS_RX_FIFO_STATS_EN to add the saturating xfer_cnt output.
module hs_rx_fifo
   import hs_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF,
   parameter int DEPTH  = 4,
   localparam int CNT_W = clog2(DEPTH) + 1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              s_valid,
   input  logic [DATA_W-1:0] s_data,
   output logic              s_ready,
   output logic              m_valid,
   output logic [DATA_W-1:0] m_data,
   input  logic              m_ready,
   output logic [CNT_W-1:0]  count,
   output logic              full,
   output logic              empty
`ifdef HS_RX_FIFO_STATS_EN
   ,
   output logic [STATS_W-1:0] xfer_cnt
`endif
);

   localparam int AW = CNT_W - 1;

   // Pointers carry one extra wrap bit so full and empty are distinguishable.
   logic [CNT_W-1:0] wr_ptr;
   logic [CNT_W-1:0] rd_ptr;
   logic             push;
   logic             pop;

   assign full    = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
   assign empty   = (wr_ptr == rd_ptr);
   assign count   = wr_ptr - rd_ptr;
   assign s_ready = !full && !reset;
   assign m_valid = !empty;
   assign push    = s_valid && s_ready;
   assign pop     = m_valid && m_ready;

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + CNT_W'(1);
         if (pop)  rd_ptr <= rd_ptr + CNT_W'(1);
      end
   end

   hs_fifo_ram #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH),
      .AW     (AW)
   ) u_ram (
      .clk   (clk),
      .we    (push),
      .waddr (wr_ptr[AW-1:0]),
      .wdata (s_data),
      .raddr (rd_ptr[AW-1:0]),
      .rdata (m_data)
   );

`ifdef HS_RX_FIFO_STATS_EN
   // Counts accepted beats only; holds at the maximum instead of wrapping.
   always_ff @(posedge clk) begin
      if (reset) begin
         xfer_cnt <= '0;
      end else if (push && (xfer_cnt != STATS_MAX)) begin
         xfer_cnt <= xfer_cnt + STATS_W'(1);
      end
   end
`endif

endmodule

// File: tb/tb_hs_rx_fifo.sv
// Self-checking bench for hs_rx_fifo: directed scenarios plus randomized
// traffic compared against a queue-based reference model.
module tb_hs_rx_fifo;

   localparam int DEPTH = 4;
   localparam int CW    = 3;

   logic        clk = 1'b0;
   logic        reset;
   logic        s_valid;
   logic [31:0] s_data;
   logic        s_ready;
   logic        m_valid;
   logic [31:0] m_data;
   logic        m_ready;
   logic [CW-1:0] count;
   logic        full;
   logic        empty;
`ifdef HS_RX_FIFO_STATS_EN
   logic [15:0] xfer_cnt;
`endif

   int total = 0;
   int bad   = 0;

   // Reference model: a plain queue of stored beats and an accepted-beat tally.
   logic [31:0] mq [$];
   int          stats_m = 0;

   always #5 clk = ~clk;

   hs_rx_fifo #(.DATA_W(32), .DEPTH(DEPTH)) dut (
      .clk      (clk),
      .reset    (reset),
      .s_valid  (s_valid),
      .s_data   (s_data),
      .s_ready  (s_ready),
      .m_valid  (m_valid),
      .m_data   (m_data),
      .m_ready  (m_ready),
      .count    (count),
      .full     (full),
      .empty    (empty)
`ifdef HS_RX_FIFO_STATS_EN
      ,
      .xfer_cnt (xfer_cnt)
`endif
   );

   always @(posedge clk) begin
      bit          pu;
      bit          po;
      logic [31:0] tmp;
      if (reset) begin
         mq.delete();
         stats_m = 0;
      end else begin
         pu = s_valid && (mq.size() < DEPTH);
         po = m_ready && (mq.size() > 0);
         if (po) tmp = mq.pop_front();
         if (pu) begin
            mq.push_back(s_data);
            if (stats_m < 65535) stats_m++;
         end
      end
   end

   task automatic tick;
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic test_reset;
      reset = 1'b1; s_valid = 1'b1; s_data = 32'hDEAD_BEEF; m_ready = 1'b0;
      #1;
      total++;
      if (s_ready !== 1'b0) begin bad++; $display("FAIL reset_s_ready: got %0b want 0", s_ready); end
      tick;
      tick;
      reset = 1'b0; s_valid = 1'b0;
      #1;
      total++;
      if (empty !== 1'b1) begin bad++; $display("FAIL reset_empty: got %0b want 1", empty); end
      total++;
      if (full !== 1'b0) begin bad++; $display("FAIL reset_full: got %0b want 0", full); end
      total++;
      if (count !== 3'd0) begin bad++; $display("FAIL reset_count: got %0d want 0", count); end
      total++;
      if (m_valid !== 1'b0) begin bad++; $display("FAIL reset_m_valid: got %0b want 0", m_valid); end
      total++;
      if (s_ready !== 1'b1) begin bad++; $display("FAIL reset_idle_s_ready: got %0b want 1", s_ready); end
`ifdef HS_RX_FIFO_STATS_EN
      total++;
      if (xfer_cnt !== 16'd0) begin bad++; $display("FAIL reset_xfer_cnt: got %0d want 0", xfer_cnt); end
`endif
      tick;
   endtask

   task automatic test_fill;
      logic [31:0] vals [4] = '{32'h11, 32'h22, 32'h33, 32'h44};
      m_ready = 1'b0;
      for (int i = 0; i < 4; i++) begin
         s_valid = 1'b1; s_data = vals[i];
         #1;
         total++;
         if (s_ready !== 1'b1) begin bad++; $display("FAIL fill_s_ready_%0d: got %0b want 1", i, s_ready); end
         tick;
         total++;
         if (count !== CW'(i + 1)) begin bad++; $display("FAIL fill_count_%0d: got %0d want %0d", i, count, i + 1); end
      end
      total++;
      if (full !== 1'b1) begin bad++; $display("FAIL fill_full: got %0b want 1", full); end
      total++;
      if (s_ready !== 1'b0) begin bad++; $display("FAIL fill_s_ready_full: got %0b want 0", s_ready); end
      s_valid = 1'b1; s_data = 32'h55;
      tick;
      tick;
      total++;
      if (count !== 3'd4) begin bad++; $display("FAIL fill_refused_count: got %0d want 4", count); end
   endtask

   task automatic test_drain;
      logic [31:0] exp_seq [5] = '{32'h11, 32'h22, 32'h33, 32'h44, 32'h55};
      int  idx = 0;
      bit  took;
      m_ready = 1'b1;
      for (int cyc = 0; cyc < 20 && idx < 5; cyc++) begin
         #1;
         if (m_valid) begin
            total++;
            if (m_data !== exp_seq[idx]) begin
               bad++; $display("FAIL drain_data_%0d: got %h want %h", idx, m_data, exp_seq[idx]);
            end
            idx++;
         end
         took = s_valid && (mq.size() < DEPTH);
         tick;
         if (took) s_valid = 1'b0;
      end
      total++;
      if (idx != 5) begin bad++; $display("FAIL drain_beats: got %0d want 5", idx); end
      total++;
      if (empty !== 1'b1) begin bad++; $display("FAIL drain_empty: got %0b want 1", empty); end
   endtask

   task automatic test_stream;
      int nexp = 1;
      s_valid = 1'b1; m_ready = 1'b1;
      for (int i = 1; i <= 10; i++) begin
         s_data = 32'(i);
         #1;
         if (m_valid) begin
            total++;
            if (m_data !== 32'(nexp)) begin bad++; $display("FAIL stream_data: got %0d want %0d", m_data, nexp); end
            nexp++;
         end
         tick;
         total++;
         if (count !== 3'd1) begin bad++; $display("FAIL stream_count_%0d: got %0d want 1", i, count); end
      end
      s_valid = 1'b0;
      #1;
      if (m_valid) begin
         total++;
         if (m_data !== 32'(nexp)) begin bad++; $display("FAIL stream_data: got %0d want %0d", m_data, nexp); end
         nexp++;
      end
      tick;
      total++;
      if (nexp != 11) begin bad++; $display("FAIL stream_beats: got %0d want 11", nexp - 1); end
      total++;
      if (empty !== 1'b1) begin bad++; $display("FAIL stream_empty: got %0b want 1", empty); end
   endtask

   task automatic test_zero_and_reset;
      m_ready = 1'b0; s_valid = 1'b1; s_data = 32'h0;
      tick;
      s_valid = 1'b0;
      #1;
      total++;
      if (m_valid !== 1'b1) begin bad++; $display("FAIL zero_m_valid: got %0b want 1", m_valid); end
      total++;
      if (m_data !== 32'h0) begin bad++; $display("FAIL zero_m_data: got %h want 0", m_data); end
      m_ready = 1'b1;
      tick;
      m_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         s_valid = 1'b1; s_data = 32'hA000_0000 + 32'(i);
         tick;
      end
      total++;
      if (count !== 3'd3) begin bad++; $display("FAIL rst_pre_count: got %0d want 3", count); end
      reset = 1'b1; s_valid = 1'b1; s_data = 32'hD00D_D00D;
      tick;
      reset = 1'b0; s_valid = 1'b0;
      #1;
      total++;
      if (count !== 3'd0) begin bad++; $display("FAIL rst_mid_count: got %0d want 0", count); end
      total++;
      if (m_valid !== 1'b0) begin bad++; $display("FAIL rst_mid_m_valid: got %0b want 0", m_valid); end
      tick;
      total++;
      if (m_valid !== 1'b0) begin bad++; $display("FAIL rst_stale_m_valid: got %0b want 0", m_valid); end
      s_valid = 1'b1; s_data = 32'hE0E0_0001;
      tick;
      s_valid = 1'b0;
      #1;
      total++;
      if (m_data !== 32'hE0E0_0001) begin bad++; $display("FAIL rst_after_data: got %h want e0e00001", m_data); end
      total++;
      if (count !== 3'd1) begin bad++; $display("FAIL rst_after_count: got %0d want 1", count); end
      m_ready = 1'b1;
      tick;
      m_ready = 1'b0;
   endtask

   task automatic test_random;
      logic [CW-1:0] exp_cnt;
      for (int c = 0; c < 400; c++) begin
         s_valid = (c % 100 < 50) ? ($urandom % 4 != 0) : ($urandom % 4 == 0);
         m_ready = (c % 100 < 50) ? ($urandom % 3 == 0) : ($urandom % 4 != 0);
         s_data  = $urandom;
         #1;
         total++;
         if (s_ready !== (mq.size() < DEPTH)) begin bad++; $display("FAIL rand_s_ready_%0d: got %0b", c, s_ready); end
         total++;
         if (m_valid !== (mq.size() != 0)) begin bad++; $display("FAIL rand_m_valid_%0d: got %0b", c, m_valid); end
         if (mq.size() != 0) begin
            total++;
            if (m_data !== mq[0]) begin bad++; $display("FAIL rand_m_data_%0d: got %h want %h", c, m_data, mq[0]); end
         end
         tick;
         exp_cnt = CW'(mq.size());
         total++;
         if (count !== exp_cnt) begin bad++; $display("FAIL rand_count_%0d: got %0d want %0d", c, count, exp_cnt); end
         total++;
         if (full !== (mq.size() == DEPTH)) begin bad++; $display("FAIL rand_full_%0d: got %0b", c, full); end
         total++;
         if (empty !== (mq.size() == 0)) begin bad++; $display("FAIL rand_empty_%0d: got %0b", c, empty); end
      end
      s_valid = 1'b0; m_ready = 1'b1;
      for (int i = 0; i < DEPTH; i++) tick;
      m_ready = 1'b0;
   endtask

`ifdef HS_RX_FIFO_STATS_EN
   task automatic test_stats;
      m_ready = 1'b0; s_valid = 1'b1; s_data = 32'h5;
      for (int i = 0; i < 8; i++) tick;
      total++;
      if (xfer_cnt !== 16'(stats_m)) begin bad++; $display("FAIL stats_refused: got %0d want %0d", xfer_cnt, stats_m); end
      m_ready = 1'b1;
      for (int i = 0; i < 70000; i++) begin
         s_data = $urandom;
         tick;
      end
      total++;
      if (xfer_cnt !== 16'hFFFF) begin bad++; $display("FAIL stats_saturate: got %h want ffff", xfer_cnt); end
      s_valid = 1'b0;
      tick;
   endtask
`endif

   initial begin
      reset = 1'b1; s_valid = 1'b0; s_data = '0; m_ready = 1'b0;
      @(negedge clk);
      test_reset;
      test_fill;
      test_drain;
      test_stream;
      test_zero_and_reset;
      test_random;
`ifdef HS_RX_FIFO_STATS_EN
      test_stats;
`endif
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
